// File: rtl/lsu_dc_way_mem.sv
// rtl/lsu_dc_way_mem.sv - LSU data-cache data array with clear sequencer, bypass and parity
//
// Purpose: NUM_WAYS x NUM_SUBBANKS x DEPTH array of DATA_W+1 bit words (even parity
// in the MSB). After reset or flush_req the array is cleared one set per cycle,
// then requests are accepted. Reads have one cycle of latency; the way-select
// mux sits after the per-way read registers, so rd_way_sel arrives a cycle after rd_en.
//
// Ports:
//   clk, rst_l          core clock, asynchronous active-low reset
//   flush_req           restart the clear sequence (RUN only)
//   ready               high while requests are accepted (RUN)
//   rd_en/rd_set        read request and set index
//   rd_way_sel          one-hot (or multi-hot) way select, cycle after rd_en
//   wr_en/wr_set        per-way write enable and set index
//   wr_sb_mask/wr_data  subbank write mask and data (subbank 0 in LSBs)
//   rd_valid/rd_data    read response, OR of selected ways
//   rd_perr             per-subbank parity error of the selected ways

module lsu_dc_way_mem #(
   parameter int NUM_WAYS     = 4,
   parameter int NUM_SUBBANKS = 2,
   parameter int DEPTH        = 128,
   parameter int DATA_W       = 32,
   parameter int SET_W        = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst_l,
   input  logic                             flush_req,
   output logic                             ready,
   input  logic                             rd_en,
   input  logic [SET_W-1:0]                 rd_set,
   input  logic [NUM_WAYS-1:0]              rd_way_sel,
   input  logic [NUM_WAYS-1:0]              wr_en,
   input  logic [SET_W-1:0]                 wr_set,
   input  logic [NUM_SUBBANKS-1:0]          wr_sb_mask,
   input  logic [NUM_SUBBANKS*DATA_W-1:0]   wr_data,
   output logic                             rd_valid,
   output logic [NUM_SUBBANKS*DATA_W-1:0]   rd_data,
   output logic [NUM_SUBBANKS-1:0]          rd_perr
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                          state_q, state_d;
   logic [SET_W-1:0]                clr_cnt_q, clr_cnt_d;
   logic                            rd_valid_q, rd_valid_d;
   logic [NUM_SUBBANKS*DATA_W-1:0]  rd_hold_q, rd_hold_d;
   logic [NUM_SUBBANKS-1:0]         perr_hold_q, perr_hold_d;
   logic                            req_ok;

   logic [DATA_W:0] mem_q     [NUM_WAYS][NUM_SUBBANKS][DEPTH];
   logic [DATA_W:0] rd_word_q [NUM_WAYS][NUM_SUBBANKS];
   logic [DATA_W:0] rd_word_d [NUM_WAYS][NUM_SUBBANKS];
   logic [NUM_SUBBANKS*DATA_W-1:0]  rd_mux;
   logic [NUM_SUBBANKS-1:0]         perr_mux;

   // Requests are dropped during the clear and on the cycle a flush is taken.
   assign req_ok = (state_q == ST_RUN) && !flush_req;

   // State register
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= ST_INIT;
         clr_cnt_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_hold_q   <= '0;
         perr_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rd_valid_q  <= rd_valid_d;
         rd_hold_q   <= rd_hold_d;
         perr_hold_q <= perr_hold_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_INIT: begin
            // Counter wraps back to 0 on the last set since DEPTH is a power of 2.
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == SET_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (flush_req) begin
               state_d   = ST_INIT;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = ST_INIT;
            clr_cnt_d = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      ready = (state_q == ST_RUN);
   end

   // Storage: not reset, cleared by the INIT sequence.
   always_ff @(posedge clk) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
         for (int s = 0; s < NUM_SUBBANKS; s++) begin
            if (state_q == ST_INIT) begin
               mem_q[w][s][clr_cnt_q] <= '0;
            end else if (req_ok && wr_en[w] && wr_sb_mask[s]) begin
               mem_q[w][s][wr_set] <= {^wr_data[s*DATA_W +: DATA_W], wr_data[s*DATA_W +: DATA_W]};
            end
         end
      end
   end

   // Per-way read capture with write-first bypass on a same-set write.
   always_comb begin
      rd_word_d  = rd_word_q;
      rd_valid_d = req_ok && rd_en;
      if (req_ok && rd_en) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < NUM_SUBBANKS; s++) begin
               if (wr_en[w] && wr_sb_mask[s] && (wr_set == rd_set)) begin
                  rd_word_d[w][s] = {^wr_data[s*DATA_W +: DATA_W], wr_data[s*DATA_W +: DATA_W]};
               end else begin
                  rd_word_d[w][s] = mem_q[w][s][rd_set];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      rd_word_q <= rd_word_d;
   end

   // Way-select mux: data ORed across selected ways, parity checked per way then ORed.
   always_comb begin
      rd_mux   = '0;
      perr_mux = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (rd_way_sel[w]) begin
            for (int s = 0; s < NUM_SUBBANKS; s++) begin
               rd_mux[s*DATA_W +: DATA_W] = rd_mux[s*DATA_W +: DATA_W] | rd_word_q[w][s][DATA_W-1:0];
               perr_mux[s]                = perr_mux[s] | (^rd_word_q[w][s]);
            end
         end
      end
   end

   // Outputs hold their last presented value when no read is returning.
   always_comb begin
      rd_valid    = rd_valid_q;
      rd_data     = rd_valid_q ? rd_mux : rd_hold_q;
      rd_perr     = rd_valid_q ? perr_mux : perr_hold_q;
      rd_hold_d   = rd_data;
      perr_hold_d = rd_perr;
   end

endmodule

// File: doc/lsu_dc_way_mem.md
Name: lsu_dc_way_mem

Overview:
- Parametrised data-cache data-array block for the LSU, replacing the fixed-geometry data-cache memory instance inside the core memory wrapper.
- Generalised in ways, sets, subbanks and word width.
- Adds three features the previous array lacks:
  - hardware clear/flush sequencer;
  - same-cycle write-to-read bypass;
  - per-subbank even-parity generation and check, with registered way-select read mux.

Parameters:
- NUM_WAYS, 4, cache ways (>=1)
- NUM_SUBBANKS, 2, 32-bit words per line slice (>=1)
- DEPTH, 128, sets per way (power of 2, >=2)
- DATA_W, 32, data bits per subbank word; storage is DATA_W+1 (parity in MSB)
- SET_W, $clog2(DEPTH), set index width (derived)

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- flush_req  in  1  pulse; restarts the clear sequence
- ready  out  1  array accepts rd/wr (high only in RUN)
- rd_en  in  1  read request
- rd_set  in  SET_W  read set index
- rd_way_sel  in  NUM_WAYS  one-hot way select, applied on the cycle after rd_en (hit_ff style)
- wr_en  in  NUM_WAYS  per-way write enable
- wr_set  in  SET_W  write set index
- wr_sb_mask  in  NUM_SUBBANKS  subbank write mask
- wr_data  in  NUM_SUBBANKS*DATA_W  write data, subbank 0 in LSBs
- rd_valid  out  1  rd_data valid
- rd_data  out  NUM_SUBBANKS*DATA_W  selected-way read data
- rd_perr  out  NUM_SUBBANKS  per-subbank parity error on rd_data

Behaviour:
- Reset (rst_l low, async):
  - state=INIT, clr_cnt=0;
  - ready=0, rd_valid=0, rd_data=0, rd_perr=0;
  - array contents are not reset, only cleared by INIT.
- FSM:
  - INIT: each cycle writes 0 (parity 0) to set clr_cnt in all ways and subbanks, then clr_cnt++. At clr_cnt==DEPTH-1 the last write occurs and the next state is RUN. INIT lasts exactly DEPTH cycles.
  - RUN: ready=1. flush_req=1 -> INIT with clr_cnt=0 on the next cycle.
- Request gating and priority:
  - In INIT, and in the RUN cycle where flush_req=1, rd_en and wr_en are ignored: no write occurs and rd_valid stays 0 next cycle.
  - flush_req during INIT is ignored; the sequence is not restarted.
- Write: in RUN, each way with wr_en[w]=1 updates the subbanks with wr_sb_mask[s]=1 at wr_set. Stored word = {^wr_data_s, wr_data_s} (even parity). Multiple ways may be written in one cycle.
- Read, 1-cycle latency:
  - rd_en in cycle N captures rd_set.
  - In cycle N+1: rd_valid=1, and rd_data/rd_perr = OR over ways w with rd_way_sel[w]=1 (sampled in N+1) of the stored words.
  - rd_way_sel all-zero -> rd_data=0, rd_perr=0.
  - Multi-hot rd_way_sel -> bitwise OR of the selected ways, parity checked per way then ORed.
  - With rd_en=0, rd_valid=0 and rd_data holds its last value.
- Bypass (write-first):
  - If in cycle N rd_en=1, wr_en[w]=1 and rd_set==wr_set, then for way w and every masked subbank the read returns the new wr_data with parity 0 (rd_perr 0).
  - Unmasked subbanks return the old contents.
- Parity check: rd_perr[s] = XOR of all DATA_W+1 stored bits of subbank s for the selected way.
- Reset mid-INIT or mid-read: immediate return to reset values; clear restarts at set 0 after rst_l rises.
- Set-index wrap: indices are modulo DEPTH by width; no out-of-range case exists.
- Test-only hook: a bench-visible force port on the storage parity bit is not provided; benches inject errors through hierarchical deposit.

Test Plan:
- Reset release, DEPTH=128 -> ready=0 for exactly 128 cycles then 1; read of set 5, way 2 (rd_way_sel=4'b0100) -> rd_data=0, rd_perr=0.
- Write 0xDEADBEEF/0x12345678 to way 1, set 0x7F, mask 2'b11; read next cycle with sel 4'b0010 -> rd_data=0x12345678_DEADBEEF, rd_perr=0, rd_valid=1 exactly one cycle after rd_en.
- Same-cycle write way 0, set 3, mask 2'b01, data 0xAAAA5555 over old 0x1111_2222 with read of set 3 -> rd_data={0x1111,0xAAAA5555} word-wise (high subbank old, low subbank new).
- Deposit a flipped bit in way 3, set 9, subbank 1; read with sel 4'b1000 -> rd_perr=2'b10. With sel 4'b0000 -> rd_data=0, rd_perr=0.
- flush_req in RUN together with rd_en and wr_en -> no write, rd_valid=0, ready low 128 cycles. Prior data reads back as 0. A second flush_req at INIT cycle 40 does not extend INIT.
- rst_l asserted at INIT cycle 60 and again one cycle after rd_en -> rd_valid=0, ready=0 immediately; full 128-cycle INIT after release.
